// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache.
// Contents:
//   DCACHE_CNT_ADDR - memory address that receives the hit count after a flush
//   dcache_state_t  - cache controller states
//   dcache_addr_t   - byte address split into tag / index / block offset / byte offset
//   dcache_frame_t  - one cache frame (valid, dirty, tag, two data words)
package cpu_types_pkg;

    localparam logic [31:0] DCACHE_CNT_ADDR = 32'h00003100;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FLUSH,
        FLUSH1,
        CNT,
        DONE
    } dcache_state_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcache_addr_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [25:0]      tag;
        logic [1:0][31:0] data;
    } dcache_frame_t;

    localparam int DCACHE_FRAME_W = $bits(dcache_frame_t);

endpackage

// File: rtl/dcache_set.sv
// One set of the 2-way data cache: both ways, the LRU bit, hit detection and
// victim selection.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset (clears valid/dirty/LRU)
//   req_tag, req_blk   tag and word offset of the current request
//   hit_en, wr_en      accepted hit this cycle (updates LRU), and whether it writes
//   wr_data            write-hit data
//   fill_en, fill_way  install a block into fill_way with fill_tag / fill_data
//   hit, rd_data       request matches a valid way; word selected from that way
//   victim_way         way to replace on a miss
//   frame0, frame1     packed dcache_frame_t view of each way (write-back / flush)
module dcache_set
    import cpu_types_pkg::*;
(
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [25:0]               req_tag,
    input  logic                      req_blk,
    input  logic                      hit_en,
    input  logic                      wr_en,
    input  logic [31:0]               wr_data,
    input  logic                      fill_en,
    input  logic                      fill_way,
    input  logic [25:0]               fill_tag,
    input  logic [63:0]               fill_data,
    output logic                      hit,
    output logic [31:0]               rd_data,
    output logic                      victim_way,
    output logic [DCACHE_FRAME_W-1:0] frame0,
    output logic [DCACHE_FRAME_W-1:0] frame1
);

    logic [1:0]       valid_reg;
    logic [1:0]       dirty_reg;
    logic             lru_reg;
    logic [25:0]      tag_reg  [2];
    logic [1:0][31:0] data_reg [2];
    logic [1:0]       match;
    logic             hit_way;
    dcache_frame_t    frame [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
            assign frame[gi] = '{valid: valid_reg[gi], dirty: dirty_reg[gi],
                                 tag: tag_reg[gi], data: data_reg[gi]};
        end
    endgenerate

    // A tag can live in only one way, so way 1 matching is enough to pick it.
    assign hit        = |match;
    assign hit_way    = match[1];
    assign rd_data    = data_reg[hit_way][req_blk];
    assign victim_way = !valid_reg[0] ? 1'b0 : (!valid_reg[1] ? 1'b1 : lru_reg);
    assign frame0     = frame[0];
    assign frame1     = frame[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= '0;
            dirty_reg <= '0;
            lru_reg   <= 1'b0;
        end else begin
            if (fill_en) begin
                valid_reg[fill_way] <= 1'b1;
                dirty_reg[fill_way] <= 1'b0;
            end
            if (hit_en) begin
                lru_reg <= ~hit_way;
                if (wr_en) begin
                    dirty_reg[hit_way] <= 1'b1;
                end
            end
        end
    end

    // Tag and data storage carries no reset; valid bits guard it.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_reg[fill_way]  <= fill_tag;
            data_reg[fill_way] <= fill_data;
        end else if (hit_en && wr_en) begin
            data_reg[hit_way][req_blk] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache.sv
// 2-way set-associative write-back data cache, 8 sets x 2-word blocks.
// Optional feature: define DCACHE_HITCOUNT_EN to count hit cycles and write the
// count to DCACHE_CNT_ADDR at the end of a flush.
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   halt                           flush all dirty frames, then stop (flushed)
//   dmemREN, dmemWEN               datapath read / write request (both = write)
//   dmemaddr, dmemstore            request byte address and write data
//   dhit, dmemload                 request completes this cycle, read data
//   flushed                        flush finished, held until reset
//   dREN, dWEN, daddr, dstore      memory-side request
//   dwait, dload                   memory busy, memory read data
module dcache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    dcache_state_t state_reg, state_next;
    logic [3:0]    flush_cnt_reg;
    logic          victim_way_reg;
    logic [31:0]   ld_word0_reg;
    dcache_addr_t  req_a;
    logic          req;
    logic          hit_ok;
    logic          fill_en;
    logic          vic_way;
    logic          fl_dirty;
    logic          unused_byte_ok;
    logic [7:0]    set_hit;
    logic [7:0]    set_victim;
    logic [31:0]   set_rd    [8];
    dcache_frame_t set_frame [8][2];
    dcache_frame_t vic_frame;
    dcache_frame_t fl_frame;

`ifdef DCACHE_HITCOUNT_EN
    localparam dcache_state_t FLUSH_END = CNT;
    logic [31:0] hit_cnt_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_reg <= '0;
        end else if (hit_ok) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
        end
    end
`else
    localparam dcache_state_t FLUSH_END = DONE;
`endif

    assign req_a          = dcache_addr_t'(dmemaddr);
    assign unused_byte_ok = ^req_a.bytoff;
    assign req            = dmemREN || dmemWEN;
    // halt wins over a coincident request so the flush starts from a quiet cache.
    assign hit_ok         = (state_reg == IDLE) && !halt && req && set_hit[req_a.idx];
    assign fill_en        = (state_reg == LD1) && !dwait;
    assign dhit           = hit_ok;
    assign dmemload       = set_rd[req_a.idx];

    // The victim is chosen live in IDLE and frozen for the rest of the miss.
    assign vic_way   = (state_reg == IDLE) ? set_victim[req_a.idx] : victim_way_reg;
    assign vic_frame = set_frame[req_a.idx][vic_way];
    assign fl_frame  = set_frame[flush_cnt_reg[3:1]][flush_cnt_reg[0]];
    assign fl_dirty  = fl_frame.valid && fl_frame.dirty;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_set
            logic [DCACHE_FRAME_W-1:0] f0, f1;
            logic                      sel;

            assign sel = (req_a.idx == 3'(gi));

            dcache_set u_set (
                .CLK        (CLK),
                .nRST       (nRST),
                .req_tag    (req_a.tag),
                .req_blk    (req_a.blkoff),
                .hit_en     (hit_ok && sel),
                .wr_en      (dmemWEN),
                .wr_data    (dmemstore),
                .fill_en    (fill_en && sel),
                .fill_way   (victim_way_reg),
                .fill_tag   (req_a.tag),
                .fill_data  ({dload, ld_word0_reg}),
                .hit        (set_hit[gi]),
                .rd_data    (set_rd[gi]),
                .victim_way (set_victim[gi]),
                .frame0     (f0),
                .frame1     (f1)
            );

            assign set_frame[gi][0] = dcache_frame_t'(f0);
            assign set_frame[gi][1] = dcache_frame_t'(f1);
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            flush_cnt_reg  <= '0;
            victim_way_reg <= 1'b0;
            ld_word0_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                victim_way_reg <= vic_way;
            end
            if ((state_reg == LD0) && !dwait) begin
                ld_word0_reg <= dload;
            end
            if (((state_reg == FLUSH) && !fl_dirty) || ((state_reg == FLUSH1) && !dwait)) begin
                flush_cnt_reg <= flush_cnt_reg + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (halt) begin
                    state_next = FLUSH;
                end else if (req && !set_hit[req_a.idx]) begin
                    state_next = (vic_frame.valid && vic_frame.dirty) ? WB0 : LD0;
                end
            end
            WB0:    if (!dwait) state_next = WB1;
            WB1:    if (!dwait) state_next = LD0;
            LD0:    if (!dwait) state_next = LD1;
            LD1:    if (!dwait) state_next = IDLE;
            FLUSH: begin
                if (fl_dirty) begin
                    if (!dwait) state_next = FLUSH1;
                end else if (flush_cnt_reg == 4'd15) begin
                    state_next = FLUSH_END;
                end
            end
            FLUSH1: begin
                if (!dwait) state_next = (flush_cnt_reg == 4'd15) ? FLUSH_END : FLUSH;
            end
            CNT:    if (!dwait) state_next = DONE;
            DONE:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = '0;
        dstore  = '0;
        flushed = 1'b0;
        case (state_reg)
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {vic_frame.tag, req_a.idx, 1'b0, 2'b00};
                dstore = vic_frame.data[0];
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {vic_frame.tag, req_a.idx, 1'b1, 2'b00};
                dstore = vic_frame.data[1];
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {req_a.tag, req_a.idx, 1'b0, 2'b00};
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {req_a.tag, req_a.idx, 1'b1, 2'b00};
            end
            FLUSH: begin
                if (fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {fl_frame.tag, flush_cnt_reg[3:1], 1'b0, 2'b00};
                    dstore = fl_frame.data[0];
                end
            end
            FLUSH1: begin
                dWEN   = 1'b1;
                daddr  = {fl_frame.tag, flush_cnt_reg[3:1], 1'b1, 2'b00};
                dstore = fl_frame.data[1];
            end
`ifdef DCACHE_HITCOUNT_EN
            CNT: begin
                dWEN   = 1'b1;
                daddr  = DCACHE_CNT_ADDR;
                dstore = hit_cnt_reg;
            end
`endif
            DONE: flushed = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: miss fill, write-back eviction, LRU choice,
// flush sequence and reset abort. Memory model holds every access busy for
// two cycles and completes it on the third.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    int n_checks = 0;
    int n_fail   = 0;
    int n_access = 0;
    int hit_cycles  = 0;
    int both_cycles = 0;
    int wait_cnt    = 0;

    logic [31:0] wdata   [4096];
    bit          written [4096];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];

    always #5 CLK = ~CLK;

    dcache dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .halt      (halt),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hAAAA0001;
            32'h44:  return 32'hAAAA0002;
            32'h140: return 32'hBBBB0001;
            32'h144: return 32'hBBBB0002;
            32'h240: return 32'hCCCC0001;
            32'h244: return 32'hCCCC0002;
            default: return {16'hD0D0, a[15:0]};
        endcase
    endfunction

    assign dwait = !((dREN || dWEN) && (wait_cnt == 2));
    assign dload = written[daddr[13:2]] ? wdata[daddr[13:2]] : init_word(daddr);

    always @(posedge CLK) begin
        if (dhit) hit_cycles <= hit_cycles + 1;
        if (dREN && dWEN) both_cycles <= both_cycles + 1;
        if ((dREN || dWEN) && (wait_cnt == 2)) begin
            wait_cnt <= 0;
            if (dWEN) begin
                written[daddr[13:2]] <= 1'b1;
                wdata[daddr[13:2]]   <= dstore;
                wr_addr_q.push_back(daddr);
                wr_data_q.push_back(dstore);
            end else begin
                rd_addr_q.push_back(daddr);
            end
        end else if (dREN || dWEN) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One datapath request; returns cycles until dhit and the read data.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd);
        @(negedge CLK);
        dmemREN   = !w;
        dmemWEN   = w;
        dmemaddr  = a;
        dmemstore = d;
        lat = 0;
        #1;
        while (!dhit && lat < 200) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        check({tag, "_dhit"}, 32'(dhit), 32'd1);
        rd = dmemload;
        n_access++;
        $display("%s %s addr=0x%08h wdata=0x%08h latency=%0d rdata=0x%08h",
                 tag, w ? "WR" : "RD", a, d, lat, rd);
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    initial begin
        int          lat;
        int          k;
        int          exp_writes;
        logic [31:0] rd;

        nRST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        #3 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_dhit",    32'(dhit),    32'd0);
        check("rst_flushed", 32'(flushed), 32'd0);
        check("rst_dREN",    32'(dREN),    32'd0);
        check("rst_dWEN",    32'(dWEN),    32'd0);
        nRST = 1'b1;

        // Cold miss, then same-block hit.
        access("miss40", 1'b0, 32'h40, 32'h0, lat, rd);
        check("miss40_lat",  32'(lat), 32'd7);
        check("miss40_data", rd, 32'hAAAA0001);
        check("miss40_nrd",  32'(rd_addr_q.size()), 32'd2);
        check("miss40_rd0",  rd_addr_q[0], 32'h40);
        check("miss40_rd1",  rd_addr_q[1], 32'h44);
        access("hit44", 1'b0, 32'h44, 32'h0, lat, rd);
        check("hit44_lat",  32'(lat), 32'd0);
        check("hit44_data", rd, 32'hAAAA0002);

        // Write hit, fill way 1, then dirty eviction of way 0.
        access("wr40", 1'b1, 32'h40, 32'h12345678, lat, rd);
        check("wr40_lat", 32'(lat), 32'd0);
        access("miss140", 1'b0, 32'h140, 32'h0, lat, rd);
        check("miss140_lat",  32'(lat), 32'd7);
        check("miss140_data", rd, 32'hBBBB0001);
        check("miss140_nwr",  32'(wr_addr_q.size()), 32'd0);
        rd_addr_q.delete();
        access("miss240", 1'b0, 32'h240, 32'h0, lat, rd);
        check("miss240_lat",  32'(lat), 32'd13);
        check("miss240_data", rd, 32'hCCCC0001);
        check("miss240_nwr",  32'(wr_addr_q.size()), 32'd2);
        check("wb_addr0", wr_addr_q[0], 32'h40);
        check("wb_data0", wr_data_q[0], 32'h12345678);
        check("wb_addr1", wr_addr_q[1], 32'h44);
        check("wb_data1", wr_data_q[1], 32'hAAAA0002);
        check("miss240_rd0", rd_addr_q[0], 32'h240);
        check("miss240_rd1", rd_addr_q[1], 32'h244);

        // Alternate hits leave 0x240 least recent; a new miss must evict it.
        access("lru140a", 1'b0, 32'h140, 32'h0, lat, rd);
        check("lru140a_lat", 32'(lat), 32'd0);
        access("lru240", 1'b0, 32'h240, 32'h0, lat, rd);
        check("lru240_lat", 32'(lat), 32'd0);
        access("lru140b", 1'b0, 32'h140, 32'h0, lat, rd);
        check("lru140b_lat", 32'(lat), 32'd0);
        access("lru40", 1'b0, 32'h40, 32'h0, lat, rd);
        check("lru40_lat",  32'(lat), 32'd7);
        check("lru40_data", rd, 32'h12345678);
        access("mru140", 1'b0, 32'h140, 32'h0, lat, rd);
        check("mru140_lat",  32'(lat), 32'd0);
        check("mru140_data", rd, 32'hBBBB0001);

        // Two dirty frames: set 0 way 0 and set 1 way 0.
        access("dirty40", 1'b1, 32'h40, 32'hDEAD0001, lat, rd);
        check("dirty40_lat", 32'(lat), 32'd0);
        access("dirty14c", 1'b1, 32'h14C, 32'hBEEF0002, lat, rd);
        check("dirty14c_lat", 32'(lat), 32'd7);

        // Flush.
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge CLK);
        halt = 1'b1;
        k = 0;
        while (!flushed && k < 300) begin
            @(negedge CLK);
            k++;
        end
        $display("flush halt cycles=%0d writes=%0d", k, wr_addr_q.size());
        check("flushed", 32'(flushed), 32'd1);
`ifdef DCACHE_HITCOUNT_EN
        exp_writes = 5;
`else
        exp_writes = 4;
`endif
        check("flush_nwr", 32'(wr_addr_q.size()), 32'(exp_writes));
        check("fl_addr0", wr_addr_q[0], 32'h40);
        check("fl_data0", wr_data_q[0], 32'hDEAD0001);
        check("fl_addr1", wr_addr_q[1], 32'h44);
        check("fl_data1", wr_data_q[1], 32'hAAAA0002);
        check("fl_addr2", wr_addr_q[2], 32'h148);
        check("fl_data2", wr_data_q[2], 32'hD0D00148);
        check("fl_addr3", wr_addr_q[3], 32'h14C);
        check("fl_data3", wr_data_q[3], 32'hBEEF0002);
`ifdef DCACHE_HITCOUNT_EN
        check("fl_addr4", wr_addr_q[4], 32'h00003100);
        check("fl_data4", wr_data_q[4], 32'(n_access));
`endif
        dmemREN  = 1'b1;
        dmemaddr = 32'h40;
        repeat (5) @(negedge CLK);
        #1;
        check("done_flushed", 32'(flushed), 32'd1);
        check("done_dhit",    32'(dhit),    32'd0);
        dmemREN = 1'b0;
        halt    = 1'b0;
        @(negedge CLK);
        check("done_hold", 32'(flushed), 32'd1);
        check("hit_once",  32'(hit_cycles), 32'(n_access));

        // Reset, rebuild a dirty way, then abort the write-back mid-WB1.
        nRST = 1'b0;
        @(negedge CLK);
        check("rst2_flushed", 32'(flushed), 32'd0);
        nRST = 1'b1;
        access("re40", 1'b0, 32'h40, 32'h0, lat, rd);
        check("re40_lat",  32'(lat), 32'd7);
        check("re40_data", rd, 32'hDEAD0001);
        access("rewr40", 1'b1, 32'h40, 32'h11112222, lat, rd);
        access("re140", 1'b0, 32'h140, 32'h0, lat, rd);
        check("re140_lat", 32'(lat), 32'd7);
        @(negedge CLK);
        dmemREN  = 1'b1;
        dmemaddr = 32'h240;
        k = 0;
        while (!(dWEN && daddr == 32'h44) && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("wb1_seen", 32'(dWEN && daddr == 32'h44), 32'd1);
        nRST = 1'b0;
        #1;
        check("abort_dWEN", 32'(dWEN), 32'd0);
        check("abort_dREN", 32'(dREN), 32'd0);
        check("abort_dhit", 32'(dhit), 32'd0);
        $display("abort reset asserted in WB1 after %0d cycles", k);
        @(negedge CLK);
        nRST    = 1'b1;
        dmemREN = 1'b0;
        access("post40", 1'b0, 32'h40, 32'h0, lat, rd);
        check("post40_lat",  32'(lat), 32'd7);
        check("post40_data", rd, 32'h11112222);
        check("never_both",  32'(both_cycles), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
